// File: rtl/retire_trace_encoder_pkg.sv
// Shared types and constants for the retire trace encoder.
// Record type codes, header layout, word counts and output FSM states.
package retire_trace_encoder_pkg;

   localparam logic [3:0] TYPE_REG = 4'd1;
   localparam logic [3:0] TYPE_MEM = 4'd2;

   localparam int HDR_TYPE_LSB  = 28;
   localparam int HDR_WSTRB_LSB = 24;
   localparam int HDR_WADDR_LSB = 16;
   localparam int HDR_SEQ_LSB   = 0;

   localparam int REG_WORDS = 3;
   localparam int MEM_WORDS = 4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_PC   = 3'd2;
   localparam logic [2:0] ST_ADDR = 3'd3;
   localparam logic [2:0] ST_DATA = 3'd4;

   // 122-bit stored record; wstrb/waddr are pre-zeroed for the other type
   typedef struct packed {
      logic        is_mem;
      logic [31:0] pc;
      logic [31:0] data;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [4:0]  waddr;
      logic [15:0] seq;
   } trace_rec_t;

   function automatic logic [31:0] make_header(trace_rec_t r);
      logic [31:0] h;
      h = '0;
      h[HDR_TYPE_LSB +: 4]  = r.is_mem ? TYPE_MEM : TYPE_REG;
      h[HDR_WSTRB_LSB +: 4] = r.wstrb;
      h[HDR_WADDR_LSB +: 5] = r.waddr;
      h[HDR_SEQ_LSB +: 16]  = r.seq;
      return h;
   endfunction

endpackage

// File: rtl/retire_trace_encoder_if.sv
// Trace word stream: valid/ready handshake with end-of-record marker.
// master drives data/valid/last, slave drives ready.
interface retire_trace_encoder_if;
   logic [31:0] trace_data;
   logic        trace_valid;
   logic        trace_ready;
   logic        trace_last;

   modport master (
      output trace_data,
      output trace_valid,
      output trace_last,
      input  trace_ready
   );

   modport slave (
      input  trace_data,
      input  trace_valid,
      input  trace_last,
      output trace_ready
   );
endinterface

// File: rtl/retire_trace_encoder_fifo.sv
// trace_fifo: synchronous record FIFO, up to two pushes (a then b) per cycle.
// Ports: clk, rst, push_a/din_a, push_b/din_b, pop, dout (head), full, empty, free_cnt.
module trace_fifo
   import retire_trace_encoder_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_a,
   input  trace_rec_t               din_a,
   input  logic                     push_b,
   input  trace_rec_t               din_b,
   input  logic                     pop,
   output trace_rec_t               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wp_q, wp_d;
   logic [AW:0] rp_q, rp_d;
   logic [AW:0] wp_b;
   logic [AW:0] cnt;
   trace_rec_t  mem_q [DEPTH];

   always_comb begin
      cnt  = wp_q - rp_q;
      wp_b = wp_q + (AW+1)'(push_a);
      wp_d = wp_b + (AW+1)'(push_b);
      rp_d = rp_q + (AW+1)'(pop);
   end

   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign free_cnt = (AW+1)'(DEPTH) - cnt;
   assign dout     = mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   // when full, the slot being popped this cycle is the one written
   always_ff @(posedge clk) begin
      if (push_a) mem_q[wp_q[AW-1:0]] <= din_a;
      if (push_b) mem_q[wp_b[AW-1:0]] <= din_b;
   end

endmodule

// File: rtl/retire_trace_encoder.sv
// Turns retired REG writes / MEM stores into sequenced trace records and serializes them.
// Ports: clk, rst, retire_* inputs, trace (stream master), overflow, drop_cnt.
module retire_trace_encoder
   import retire_trace_encoder_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          retire_valid,
   input  logic [69:0]                   inst_retire,
   input  logic                          retire_mem_wen,
   input  logic [31:0]                   retire_mem_addr,
   input  logic [31:0]                   retire_mem_wdata,
   input  logic [3:0]                    retire_mem_wstrb,
   retire_trace_encoder_if.master        trace,
   output logic                          overflow,
   output logic [15:0]                   drop_cnt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [2:0]  state_q, state_d;
   logic [15:0] seq_q, seq_d;
   logic        overflow_q, overflow_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic        gen_reg, gen_mem;
   logic        keep_reg, keep_mem;
   logic        avail_ge1, avail_ge2;
   logic [1:0]  n_drop;
   logic [16:0] drop_sum;
   trace_rec_t  reg_rec, mem_rec, head;
   logic        push_a, push_b, pop;
   trace_rec_t  din_a;
   logic        full, empty;
   logic [CW-1:0] free_cnt;
   logic        valid, acc, more;
   logic [31:0] word;

   assign gen_reg = retire_valid & inst_retire[69] & (inst_retire[68:64] != 5'd0);
   assign gen_mem = retire_valid & retire_mem_wen;

   always_comb begin
      reg_rec        = '0;
      reg_rec.is_mem = 1'b0;
      reg_rec.pc     = inst_retire[31:0];
      reg_rec.data   = inst_retire[63:32];
      reg_rec.waddr  = inst_retire[68:64];
      reg_rec.seq    = seq_q;

      mem_rec        = '0;
      mem_rec.is_mem = 1'b1;
      mem_rec.pc     = inst_retire[31:0];
      mem_rec.data   = retire_mem_wdata;
      mem_rec.addr   = retire_mem_addr;
      mem_rec.wstrb  = retire_mem_wstrb;
      mem_rec.seq    = seq_q + 16'(gen_reg);
   end

   // free space counts the slot released by a same-cycle pop
   assign avail_ge1 = ~full | pop;
   assign avail_ge2 = (free_cnt >= CW'(2)) | ((free_cnt == CW'(1)) & pop);

   assign keep_reg = gen_reg & avail_ge1;
   assign keep_mem = gen_mem & (gen_reg ? avail_ge2 : avail_ge1);
   assign n_drop   = 2'(gen_reg & ~keep_reg) + 2'(gen_mem & ~keep_mem);

   assign push_a = keep_reg | keep_mem;
   assign din_a  = keep_reg ? reg_rec : mem_rec;
   assign push_b = keep_reg & keep_mem;

   trace_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_a   (push_a),
      .din_a    (din_a),
      .push_b   (push_b),
      .din_b    (mem_rec),
      .pop      (pop),
      .dout     (head),
      .full     (full),
      .empty    (empty),
      .free_cnt (free_cnt)
   );

   assign valid = (state_q != ST_IDLE);
   assign acc   = valid & trace.trace_ready;
   assign pop   = (state_q == ST_DATA) & acc;
   // another record stays queued behind the one being popped
   assign more  = (free_cnt < CW'(FIFO_DEPTH - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (!empty) state_d = ST_HDR;
         ST_HDR:  if (acc) state_d = ST_PC;
         ST_PC:   if (acc) state_d = head.is_mem ? ST_ADDR : ST_DATA;
         ST_ADDR: if (acc) state_d = ST_DATA;
         ST_DATA: if (acc) state_d = more ? ST_HDR : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      word = '0;
      unique case (state_q)
         ST_HDR:  word = make_header(head);
         ST_PC:   word = head.pc;
         ST_ADDR: word = head.addr;
         ST_DATA: word = head.data;
         default: word = '0;
      endcase
   end

   always_comb begin
      seq_d      = seq_q + 16'(gen_reg) + 16'(gen_mem);
      overflow_d = overflow_q | (n_drop != 2'd0);
      drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign trace.trace_data  = word;
   assign trace.trace_valid = valid;
   assign trace.trace_last  = (state_q == ST_DATA);
   assign overflow          = overflow_q;
   assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_encoder.sv
// Bench for retire_trace_encoder: directed cases plus random traffic.
// A record-queue model predicts every output word, handshake and drop count.
module tb_retire_trace_encoder;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv, rf_en, mwen, ready;
   logic [4:0]  waddr;
   logic [31:0] pc, rdata, maddr, mdata;
   logic [3:0]  wstrb;
   logic [69:0] inst;
   logic        ovf;
   logic [15:0] dcnt;

   retire_trace_encoder_if tif ();

   assign inst            = {rf_en, waddr, rdata, pc};
   assign tif.trace_ready = ready;

   retire_trace_encoder #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .retire_valid     (rv),
      .inst_retire      (inst),
      .retire_mem_wen   (mwen),
      .retire_mem_addr  (maddr),
      .retire_mem_wdata (mdata),
      .retire_mem_wstrb (wstrb),
      .trace            (tif),
      .overflow         (ovf),
      .drop_cnt         (dcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                pe;
      int                len;
      logic [3:0][31:0]  w;
   } rec_t;

   rec_t        q[$];
   int          e = 0;
   int          idx = 0;
   logic [15:0] m_seq = 0;
   logic        m_ovf = 0;
   logic [15:0] m_drop = 0;
   int          tot = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tot++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic add_rec(input bit is_mem);
      rec_t r;
      r.pe = e;
      r.w[1] = pc;
      if (is_mem) begin
         r.w[0] = {4'd2, wstrb, 3'b000, 5'd0, m_seq};
         r.w[2] = maddr;
         r.w[3] = mdata;
         r.len  = 4;
      end else begin
         r.w[0] = {4'd1, 4'd0, 3'b000, waddr, m_seq};
         r.w[2] = rdata;
         r.w[3] = '0;
         r.len  = 3;
      end
      if (q.size() < DEPTH) q.push_back(r);
      else begin
         m_ovf = 1'b1;
         if (m_drop != 16'hFFFF) m_drop++;
      end
      m_seq++;
   endtask

   task automatic model_step();
      e++;
      if (rst) begin
         q.delete();
         idx = 0;
         m_seq = 0;
         m_ovf = 0;
         m_drop = 0;
         return;
      end
      if (q.size() > 0 && q[0].pe < e - 1 && ready) begin
         idx++;
         if (idx == q[0].len) begin
            void'(q.pop_front());
            idx = 0;
         end
      end
      if (rv) begin
         if (rf_en && waddr != 5'd0) add_rec(1'b0);
         if (mwen) add_rec(1'b1);
      end
   endtask

   task automatic check_all();
      logic vexp;
      vexp = (q.size() > 0) && (q[0].pe < e);
      chk("valid", 32'(tif.trace_valid), 32'(vexp));
      if (vexp) begin
         chk("data", tif.trace_data, q[0].w[idx]);
         chk("last", 32'(tif.trace_last), 32'(idx == q[0].len - 1));
      end
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("drop_cnt", 32'(dcnt), 32'(m_drop));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle_in();
      rv = 0; rf_en = 0; mwen = 0; waddr = 0;
      pc = 0; rdata = 0; maddr = 0; mdata = 0; wstrb = 0;
   endtask

   task automatic set_reg(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
      idle_in();
      rv = 1; rf_en = 1; pc = p; waddr = a; rdata = d;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1;
      cyc();
      rst = 0;
   endtask

   initial begin
      idle_in();
      ready = 1;
      rst = 1;
      cyc();
      chk("rst_valid", 32'(tif.trace_valid), 32'd0);
      chk("rst_data", tif.trace_data, 32'd0);
      chk("rst_last", 32'(tif.trace_last), 32'd0);
      rst = 0;

      // single REG record, header one cycle after the sampling edge
      set_reg(32'hBFC00000, 5'd8, 32'h12345678);
      cyc();
      idle_in();
      chk("lat_novalid", 32'(tif.trace_valid), 32'd0);
      cyc();
      chk("reg_hdr", tif.trace_data, 32'h10080000);
      cyc();
      chk("reg_pc", tif.trace_data, 32'hBFC00000);
      cyc();
      chk("reg_data", tif.trace_data, 32'h12345678);
      chk("reg_last", 32'(tif.trace_last), 32'd1);
      cyc();

      // MEM store with seq 1
      idle_in();
      rv = 1; mwen = 1; pc = 32'h100; maddr = 32'h0C; mdata = 0; wstrb = 4'hF;
      cyc();
      idle_in();
      cyc();
      chk("mem_hdr", tif.trace_data, 32'h2F000001);
      repeat (4) cyc();

      // x0 write generates nothing
      set_reg(32'h200, 5'd0, 32'hDEAD);
      cyc();
      idle_in();
      repeat (3) cyc();
      chk("x0_none", 32'(tif.trace_valid), 32'd0);
      set_reg(32'h204, 5'd1, 32'h1);
      cyc();
      idle_in();
      cyc();
      chk("seq_after_x0", tif.trace_data, 32'h10010002);
      repeat (3) cyc();

      // overflow with ready low
      do_reset();
      ready = 0;
      for (int i = 0; i < 10; i++) begin
         set_reg(32'h1000 + 32'(i * 4), 5'd5, 32'(i));
         cyc();
      end
      idle_in();
      cyc();
      chk("ovf_flag", 32'(ovf), 32'd1);
      chk("ovf_cnt", 32'(dcnt), 32'd2);
      ready = 1;
      repeat (30) cyc();

      // one free slot: REG kept, MEM dropped; then both dropped
      do_reset();
      ready = 0;
      for (int i = 0; i < 7; i++) begin
         set_reg(32'h2000 + 32'(i), 5'd2, 32'(i));
         cyc();
      end
      set_reg(32'h3000, 5'd9, 32'hAA);
      mwen = 1; maddr = 32'h40; mdata = 32'h55; wstrb = 4'h3;
      cyc();
      chk("one_slot_cnt", 32'(dcnt), 32'd1);
      cyc();
      chk("zero_slot_cnt", 32'(dcnt), 32'd3);
      idle_in();
      ready = 1;
      repeat (35) cyc();

      // toggled ready during a MEM record
      idle_in();
      rv = 1; mwen = 1; pc = 32'h300; maddr = 32'h80; mdata = 32'hCAFE; wstrb = 4'h1;
      cyc();
      idle_in();
      for (int i = 0; i < 12; i++) begin
         ready = ~ready;
         cyc();
      end
      ready = 1;
      repeat (3) cyc();

      // reset in the middle of a REG record
      set_reg(32'h400, 5'd4, 32'h44);
      cyc();
      idle_in();
      repeat (3) cyc();
      rst = 1;
      cyc();
      rst = 0;
      chk("midrst_valid", 32'(tif.trace_valid), 32'd0);
      set_reg(32'h500, 5'd3, 32'h33);
      cyc();
      idle_in();
      cyc();
      chk("midrst_hdr", tif.trace_data, 32'h10030000);
      repeat (3) cyc();

      // random traffic, alternating ready pressure
      for (int ph = 0; ph < 6; ph++) begin
         for (int i = 0; i < 400; i++) begin
            rv    = ($urandom_range(0, 3) != 0);
            rf_en = $urandom_range(0, 1);
            waddr = 5'($urandom_range(0, 31));
            mwen  = ($urandom_range(0, 2) == 0);
            pc    = $urandom;
            rdata = $urandom;
            maddr = $urandom;
            mdata = $urandom;
            wstrb = 4'($urandom);
            ready = (ph % 2 == 0) ? ($urandom_range(0, 9) != 0)
                                  : ($urandom_range(0, 9) < 3);
            rst   = ($urandom_range(0, 499) == 0);
            cyc();
         end
      end
      rst = 0;
      idle_in();
      ready = 1;
      repeat (50) cyc();

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
